tetris_line_clear: RTL and testbench

//  Row-clear engine directly downstream of the piece-placement logic in the VGA Tetris controller.
//  - On each placement it takes the 150-bit placed-block board and removes every full row.
//  - Rows above each cleared row collapse downward.
//  - It reports the number of cleared lines and keeps a running score.
//  - board_out is written back as the new placed-block board and read by the renderer.

---
 rtl/tetris_line_clear_pkg.sv | 34 +++
 rtl/tetris_row_collapse.sv | 24 ++
 rtl/tetris_line_clear.sv | 122 ++++++++++++
 tb/tb_tetris_line_clear.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_line_clear_pkg.sv
// Shared board geometry, scoring constants and FSM state type for the line-clear engine.
package tetris_line_clear_pkg;

  localparam int DEF_COLS    = 10;
  localparam int DEF_ROWS    = 15;
  localparam int DEF_SCORE_W = 16;
  localparam int BLOCK_SIZE  = 32;

  localparam int PTS_W = 11;
  localparam logic [PTS_W-1:0] PTS_1 = 11'd40;
  localparam logic [PTS_W-1:0] PTS_2 = 11'd100;
  localparam logic [PTS_W-1:0] PTS_3 = 11'd300;
  localparam logic [PTS_W-1:0] PTS_4 = 11'd1200;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_DONE
  } state_e;

  function automatic logic [PTS_W-1:0] line_pts(input int unsigned n);
    logic [PTS_W-1:0] p;
    case (n)
      0:       p = '0;
      1:       p = PTS_1;
      2:       p = PTS_2;
      3:       p = PTS_3;
      default: p = PTS_4;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tetris_row_collapse.sv
// Combinational row test and collapse: reports whether row_i is full and returns
// the board with rows 1..row_i pulled down by one and row 0 cleared.
module tetris_row_collapse #(
  parameter int COLS = 10,
  parameter int ROWS = 15,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic [ROWS*COLS-1:0] board_i,
  input  logic [RW-1:0]        row_i,
  output logic                 row_full_o,
  output logic [ROWS*COLS-1:0] board_o
);

  always_comb begin
    board_o    = board_i;
    row_full_o = &board_i[32'(row_i)*COLS +: COLS];
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r <= 32'(row_i)) begin
        board_o[r*COLS +: COLS] = (r == 0) ? '0 : board_i[(r-1)*COLS +: COLS];
      end
    end
  end

endmodule

// File: rtl/tetris_line_clear.sv
// Row-clear engine: scans the placed-block board bottom-up, removes full rows,
// collapses the rows above, and keeps a saturating running score.
module tetris_line_clear
  import tetris_line_clear_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ROWS*COLS-1:0]       board_in,
  output logic                       busy,
  output logic                       done,
  output logic [ROWS*COLS-1:0]       board_out,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  output logic [SCORE_W-1:0]         score
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(ROWS+1);
  localparam int SW1 = SCORE_W + 1;

  state_e                state_q, state_d;
  logic [ROWS*COLS-1:0]  work_q, work_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ROWS*COLS-1:0]  bout_q, bout_d;
  logic [CW-1:0]         lines_q, lines_d;
  logic [SCORE_W-1:0]    score_q, score_d;

  logic                  row_full;
  logic [ROWS*COLS-1:0]  shifted;
  logic [SCORE_W:0]      score_sum;

  tetris_row_collapse #(
    .COLS (COLS),
    .ROWS (ROWS),
    .RW   (RW)
  ) u_collapse (
    .board_i    (work_q),
    .row_i      (row_q),
    .row_full_o (row_full),
    .board_o    (shifted)
  );

  // Extra headroom bit lets an overflowing add be detected and clamped.
  assign score_sum = {1'b0, score_q} + SW1'(line_pts(32'(cnt_q)));

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    bout_d  = bout_q;
    lines_d = lines_q;
    score_d = score_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = board_in;
          row_d   = RW'(ROWS - 1);
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (row_full) begin
          state_d = S_SHIFT;
        end else if (row_q == '0) begin
          // Results are loaded on entry so they are valid during the done cycle.
          state_d = S_DONE;
          bout_d  = work_q;
          lines_d = cnt_q;
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end else begin
          row_d = row_q - RW'(1);
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        work_d  = shifted;
        cnt_d   = cnt_q + CW'(1);
        state_d = S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      bout_q  <= '0;
      lines_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      bout_q  <= bout_d;
      lines_q <= lines_d;
      score_q <= score_d;
    end
  end

  assign board_out     = bout_q;
  assign lines_cleared = lines_q;
  assign score         = score_q;

endmodule

// File: tb/tb_tetris_line_clear.sv
// Self-checking bench for tetris_line_clear: vector table, random boards against a
// compaction model, and hand-written sequences for reset, ignored starts and saturation.
module tb_tetris_line_clear;

  localparam int NB    = 150;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            start1, busy1, done1;
  logic [NB-1:0]   board1, bout1;
  logic [3:0]      lines1;
  logic [15:0]     score1;

  logic            start2, busy2, done2;
  logic [NB-1:0]   board2, bout2;
  logic [3:0]      lines2;
  logic [10:0]     score2;

  tetris_line_clear u_dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start1),
    .board_in      (board1),
    .busy          (busy1),
    .done          (done1),
    .board_out     (bout1),
    .lines_cleared (lines1),
    .score         (score1)
  );

  tetris_line_clear #(.SCORE_W(11)) u_dut_sat (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start2),
    .board_in      (board2),
    .busy          (busy2),
    .done          (done2),
    .board_out     (bout2),
    .lines_cleared (lines2),
    .score         (score2)
  );

  typedef struct {
    logic [NB-1:0] board;
    int            lines;
    int            score;
    int            lat;
  } exp_t;

  typedef struct {
    string         name;
    logic [NB-1:0] b;
    logic [NB-1:0] eb;
    int            lines;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[8];
  int   errors = 0;
  int   checks = 0;
  int   model_score[2];
  int   score_max[2];

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] rowv(input int r, input logic [9:0] v);
    logic [NB-1:0] t;
    t = '0;
    t[r*10 +: 10] = v;
    return t;
  endfunction

  function automatic int pts(input int n);
    if (n == 0) return 0;
    if (n == 1) return 40;
    if (n == 2) return 100;
    if (n == 3) return 300;
    return 1200;
  endfunction

  // Reference: keep non-full rows in bottom-up order, packed against the bottom.
  function automatic logic [NB-1:0] compact(input logic [NB-1:0] b, output int n);
    logic [NB-1:0] o;
    int dst;
    o = '0;
    dst = 14;
    n = 0;
    for (int r = 14; r >= 0; r--) begin
      if (b[r*10 +: 10] == 10'h3FF) n++;
      else begin
        o[dst*10 +: 10] = b[r*10 +: 10];
        dst--;
      end
    end
    return o;
  endfunction

  function automatic logic dsel(input int sel);
    return (sel == 0) ? done1 : done2;
  endfunction

  task automatic expect_pass(input int sel, input logic [NB-1:0] eb, input int lines);
    exp_t e;
    model_score[sel] = model_score[sel] + pts(lines);
    if (model_score[sel] > score_max[sel]) model_score[sel] = score_max[sel];
    e.board = eb;
    e.lines = lines;
    e.score = model_score[sel];
    e.lat   = 15 + 2 * lines;
    sbq.push_back(e);
  endtask

  // Leaves time at start edge + 1; board_in is scrambled after acceptance.
  task automatic launch(input int sel, input logic [NB-1:0] b);
    @(posedge clk);
    #1;
    if (sel == 0) begin start1 = 1'b1; board1 = b; end
    else          begin start2 = 1'b1; board2 = b; end
    @(posedge clk);
    #1;
    if (sel == 0) begin start1 = 1'b0; board1 = ~b; end
    else          begin start2 = 1'b0; board2 = ~b; end
  endtask

  task automatic finish_pass(input int sel, input string nm, input int edges0);
    int   edges;
    exp_t e;
    edges = edges0;
    while (!dsel(sel) && edges < LIMIT) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = sbq.pop_front();
    if (!dsel(sel)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done after %0d edges, expected at %0d", nm, edges, e.lat);
    end else begin
      chk({nm, " latency"}, NB'(edges), NB'(e.lat));
      if (sel == 0) begin
        chk({nm, " lines"}, NB'(lines1), NB'(e.lines));
        chk({nm, " board"}, bout1, e.board);
        chk({nm, " score"}, NB'(score1), NB'(e.score));
      end else begin
        chk({nm, " lines"}, NB'(lines2), NB'(e.lines));
        chk({nm, " board"}, bout2, e.board);
        chk({nm, " score"}, NB'(score2), NB'(e.score));
      end
    end
  endtask

  task automatic do_pass(input int sel, input string nm, input logic [NB-1:0] b,
                         input logic [NB-1:0] eb, input int lines);
    expect_pass(sel, eb, lines);
    launch(sel, b);
    chk({nm, " busy"}, NB'((sel == 0) ? busy1 : busy2), NB'(1));
    finish_pass(sel, nm, 0);
  endtask

  task automatic no_done_for(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done1) seen++;
    end
    chk(nm, NB'(seen), NB'(0));
  endtask

  initial begin
    logic [NB-1:0] rb, reb;
    int            rn;

    score_max[0] = 65535;
    score_max[1] = 2047;
    model_score[0] = 0;
    model_score[1] = 0;

    vt[0] = '{"empty",     '0, '0, 0};
    vt[1] = '{"row14",     rowv(14, 10'h3FF) | rowv(13, 10'h008), rowv(14, 10'h008), 1};
    vt[2] = '{"rows14_12", rowv(14, 10'h3FF) | rowv(13, 10'h001) | rowv(12, 10'h3FF),
                           rowv(14, 10'h001), 2};
    vt[3] = '{"rows11_14", rowv(14, 10'h3FF) | rowv(13, 10'h3FF) | rowv(12, 10'h3FF)
                           | rowv(11, 10'h3FF), '0, 4};
    vt[4] = '{"full",      '1, '0, 15};
    vt[5] = '{"nonadj",    rowv(14, 10'h3FF) | rowv(12, 10'h2AA) | rowv(10, 10'h3FF)
                           | rowv(0, 10'h155), rowv(13, 10'h2AA) | rowv(2, 10'h155), 2};
    vt[6] = '{"row0",      rowv(0, 10'h3FF) | rowv(1, 10'h0F0), rowv(1, 10'h0F0), 1};
    vt[7] = '{"row5",      rowv(5, 10'h3FF) | rowv(6, 10'h3FE) | rowv(4, 10'h001),
                           rowv(6, 10'h3FE) | rowv(5, 10'h001), 1};

    rst_n = 1'b0;
    start1 = 1'b0; board1 = '0;
    start2 = 1'b0; board2 = '0;
    #3;
    chk("reset busy",  NB'(busy1),  NB'(0));
    chk("reset done",  NB'(done1),  NB'(0));
    chk("reset board", bout1,       '0);
    chk("reset lines", NB'(lines1), NB'(0));
    chk("reset score", NB'(score1), NB'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back passes: each start lands in the cycle after the previous done.
    for (int i = 0; i < 8; i++) begin
      do_pass(0, vt[i].name, vt[i].b, vt[i].eb, vt[i].lines);
    end

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 15; r++) begin
        rb[r*10 +: 10] = ($urandom_range(0, 2) == 0) ? 10'h3FF : 10'($urandom);
      end
      reb = compact(rb, rn);
      do_pass(0, "random", rb, reb, rn);
    end

    // Start asserted while in the done cycle must be dropped.
    start1 = 1'b1;
    board1 = '1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("start in done ignored busy", NB'(busy1), NB'(0));
    no_done_for("start in done stray done", 50);

    // Start re-pulsed while busy: one done carrying the first board's result.
    expect_pass(0, rowv(14, 10'h00F), 1);
    launch(0, rowv(14, 10'h3FF) | rowv(13, 10'h00F));
    repeat (3) begin @(posedge clk); #1; end
    start1 = 1'b1;
    board1 = '1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    finish_pass(0, "start while busy", 4);
    no_done_for("start while busy second done", 60);

    do_pass(1, "sat first",  vt[3].b, '0, 4);
    do_pass(1, "sat clamp",  vt[3].b, '0, 4);
    do_pass(1, "sat hold",   vt[3].b, '0, 4);

    // Reset while the engine is shifting.
    launch(0, '1);
    @(posedge clk);
    #1;
    chk("pre-reset busy", NB'(busy1), NB'(1));
    rst_n = 1'b0;
    #1;
    chk("mid reset busy",  NB'(busy1),  NB'(0));
    chk("mid reset done",  NB'(done1),  NB'(0));
    chk("mid reset board", bout1,       '0);
    chk("mid reset lines", NB'(lines1), NB'(0));
    chk("mid reset score", NB'(score1), NB'(0));
    chk("mid reset score sat", NB'(score2), NB'(0));
    model_score[0] = 0;
    model_score[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_pass(0, "after reset", vt[1].b, vt[1].eb, 1);

    chk("scoreboard empty", NB'(sbq.size()), NB'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
